// File: rtl/epu.sv
// Signature-check engine over GF(2^255-19): result = ((R + h*A) mod p == S mod p).
// One request at a time; a bit-serial double-and-add multiplier keeps the datapath at 257 bits.
module epu (
  input  logic         axiclk,
  input  logic         resetn,
  input  logic         valid,
  input  logic [511:0] sig,
  input  logic [255:0] key,
  input  logic [255:0] rhash,
  output logic         ready,
  output logic         result
);

  localparam logic [255:0] P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    MUL    = 3'd2,
    ADD    = 3'd3,
    CMP    = 3'd4
  } state_t;

  state_t       state_r;
  logic [255:0] a_r;
  logic [255:0] r_r;
  logic [255:0] s_r;
  logic [255:0] h_r;
  logic [255:0] acc_r;
  logic [7:0]   cnt_r;

  // Single conditional subtract; callers guarantee v < 2p so the result is < p.
  function automatic logic [255:0] cond_sub(input logic [256:0] v);
    logic [256:0] d;
    if (v >= {1'b0, P}) begin
      d = v - {1'b0, P};
    end else begin
      d = v;
    end
    cond_sub = d[255:0];
  endfunction

  function automatic logic [255:0] mod_dbl(input logic [255:0] x);
    mod_dbl = cond_sub({x, 1'b0});
  endfunction

  function automatic logic [255:0] mod_add(input logic [255:0] x, input logic [255:0] y);
    mod_add = cond_sub({1'b0, x} + {1'b0, y});
  endfunction

  // Control FSM and datapath; acc_r doubles as the (acc + R) sum in ADD.
  always_ff @(posedge axiclk) begin
    if (!resetn) begin
      state_r <= IDLE;
      ready   <= 1'b1;
      result  <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid) begin
            a_r     <= key;
            r_r     <= sig[511:256];
            s_r     <= sig[255:0];
            h_r     <= rhash;
            acc_r   <= 256'd0;
            cnt_r   <= 8'd0;
            ready   <= 1'b0;
            state_r <= REDUCE;
          end
        end
        REDUCE: begin
          // Raw inputs are below 2^256 = 2p + 38, so two passes always land below p.
          a_r <= cond_sub({1'b0, a_r});
          r_r <= cond_sub({1'b0, r_r});
          s_r <= cond_sub({1'b0, s_r});
          if (cnt_r == 8'd1) begin
            cnt_r   <= 8'd0;
            state_r <= MUL;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        MUL: begin
          if (h_r[255]) begin
            acc_r <= mod_add(mod_dbl(acc_r), a_r);
          end else begin
            acc_r <= mod_dbl(acc_r);
          end
          h_r   <= {h_r[254:0], 1'b0};
          cnt_r <= cnt_r + 8'd1;
          if (cnt_r == 8'd255) begin
            state_r <= ADD;
          end
        end
        ADD: begin
          acc_r   <= mod_add(acc_r, r_r);
          state_r <= CMP;
        end
        CMP: begin
          result  <= (acc_r == s_r);
          ready   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          ready   <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epu.sv
// Directed-vector and randomized bench for epu; expected values come from hand arithmetic
// and a wide-integer golden model (full product then remainder).
module tb_epu;

  localparam logic [255:0] P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] ALL1 = {256{1'b1}};

  logic         axiclk = 1'b0;
  logic         resetn = 1'b0;
  logic         valid = 1'b0;
  logic [511:0] sig = 512'd0;
  logic [255:0] key = 256'd0;
  logic [255:0] rhash = 256'd0;
  logic         ready;
  logic         result;

  int total = 0;
  int bad = 0;

  epu dut (
    .axiclk(axiclk),
    .resetn(resetn),
    .valid(valid),
    .sig(sig),
    .key(key),
    .rhash(rhash),
    .ready(ready),
    .result(result)
  );

  always #5 axiclk = ~axiclk;

  typedef struct {
    logic [255:0] r;
    logic [255:0] s;
    logic [255:0] k;
    logic [255:0] h;
    logic         exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] gold_lhs(input logic [255:0] r, input logic [255:0] k,
                                            input logic [255:0] h);
    logic [519:0] w;
    logic [519:0] m;
    w = {264'd0, h} * {264'd0, k} + {264'd0, r};
    m = w % {264'd0, P};
    return m[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // Issue one request and wait for completion; checks acceptance and 260-cycle latency.
  task automatic run_req(input logic [255:0] r, input logic [255:0] s, input logic [255:0] k,
                         input logic [255:0] h, output logic res);
    logic prev;
    int   cnt;
    prev  = result;
    sig   = {r, s};
    key   = k;
    rhash = h;
    valid = 1'b1;
    @(posedge axiclk);
    #1;
    valid = 1'b0;
    sig   = 512'd0;
    key   = 256'd0;
    rhash = 256'd0;
    chk("accept_ready_low", {255'd0, ready}, 256'd0);
    chk("result_hold_at_accept", {255'd0, result}, {255'd0, prev});
    cnt = 0;
    while (cnt < 400 && ready !== 1'b1) begin
      @(posedge axiclk);
      #1;
      cnt++;
    end
    chk("latency", 256'(cnt), 256'd260);
    res = result;
  endtask

  initial begin
    logic res;
    int   cnt;
    logic flag;
    logic [255:0] r, s, k, h, lhs;

    vecs[0] = '{r: 256'd5, s: 256'd6, k: 256'd1, h: 256'd1, exp: 1'b1};
    vecs[1] = '{r: 256'd5, s: 256'd7, k: 256'd1, h: 256'd1, exp: 1'b0};
    vecs[2] = '{r: 256'd0, s: 256'd6, k: P + 256'd3, h: 256'd2, exp: 1'b1};
    vecs[3] = '{r: 256'd0, s: P + 256'd6, k: P + 256'd3, h: 256'd2, exp: 1'b1};
    vecs[4] = '{r: 256'd0, s: ALL1, k: ALL1, h: 256'd1, exp: 1'b1};
    vecs[5] = '{r: 256'd2, s: 256'd0, k: P - 256'd1, h: 256'd2, exp: 1'b1};
    vecs[6] = '{r: 256'd9, s: 256'd9, k: 256'h1234_5678_9abc_def0, h: 256'd0, exp: 1'b1};
    vecs[7] = '{r: P, s: 256'd0, k: 256'd77, h: 256'd0, exp: 1'b1};
    vecs[8] = '{r: ALL1, s: 256'd37, k: 256'd3, h: 256'd0, exp: 1'b1};

    // Reset held for two edges.
    repeat (2) @(posedge axiclk);
    #1;
    chk("reset_ready", {255'd0, ready}, 256'd1);
    chk("reset_result", {255'd0, result}, 256'd0);
    resetn = 1'b1;

    // Directed vectors; the first is offered on the very first edge out of reset.
    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].r, vecs[i].s, vecs[i].k, vecs[i].h, res);
      chk($sformatf("vec%0d_result", i), {255'd0, res}, {255'd0, vecs[i].exp});
    end

    // Back-to-back: previous call returned right after ready rose; next request goes on the next edge.
    run_req(256'd5, 256'd6, 256'd1, 256'd1, res);
    chk("b2b_first", {255'd0, res}, 256'd1);
    run_req(256'd5, 256'd7, 256'd1, 256'd1, res);
    chk("b2b_second", {255'd0, res}, 256'd0);

    // Ignored valid pulses at +10, +200 and on the completing edge.
    sig = {256'd5, 256'd6}; key = 256'd1; rhash = 256'd1; valid = 1'b1;
    @(posedge axiclk);
    #1;
    valid = 1'b0;
    cnt = 0;
    while (cnt < 400 && ready !== 1'b1) begin
      valid = (cnt == 10 || cnt == 200 || cnt == 259);
      @(posedge axiclk);
      #1;
      cnt++;
    end
    valid = 1'b0;
    chk("hs_latency", 256'(cnt), 256'd260);
    chk("hs_result", {255'd0, result}, 256'd1);
    flag = 1'b0;
    repeat (5) begin
      @(posedge axiclk);
      #1;
      if (ready !== 1'b1) flag = 1'b1;
    end
    chk("hs_no_extra_accept", {255'd0, flag}, 256'd0);

    // Reset during MUL abandons the request.
    sig = {256'd5, 256'd6}; key = 256'd1; rhash = 256'd1; valid = 1'b1;
    @(posedge axiclk);
    #1;
    valid = 1'b0;
    repeat (100) @(posedge axiclk);
    #1;
    chk("mid_busy", {255'd0, ready}, 256'd0);
    resetn = 1'b0;
    @(posedge axiclk);
    #1;
    resetn = 1'b1;
    chk("mid_reset_ready", {255'd0, ready}, 256'd1);
    chk("mid_reset_result", {255'd0, result}, 256'd0);
    flag = 1'b0;
    repeat (300) begin
      @(posedge axiclk);
      #1;
      if (ready !== 1'b1 || result !== 1'b0) flag = 1'b1;
    end
    chk("mid_no_completion", {255'd0, flag}, 256'd0);

    // Random requests against the golden model; even iterations force a matching S.
    for (int i = 0; i < 50; i++) begin
      r = rand256();
      k = rand256();
      h = rand256();
      lhs = gold_lhs(r, k, h);
      if (i % 2 == 0) s = lhs;
      else s = rand256();
      run_req(r, s, k, h, res);
      chk($sformatf("rand%0d_result", i), {255'd0, res},
          {255'd0, (lhs == gold_lhs(s, 256'd0, 256'd0))});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/epu.md
EPU -- requirements
Module: epu

Interface
REQ-001 The module SHALL have no parameters; the field prime is fixed at p = 2^255 - 19.
REQ-002 axiclk  input  1  Sole clock; all state updates occur on its rising edge.
REQ-003 resetn  input  1  Reset, synchronous and active-low.
REQ-004 valid  input  1  Request strobe; sampled only while ready=1.
REQ-005 sig  input  512  Signature: R = sig[511:256], S = sig[255:0].
REQ-006 key  input  256  Public operand A, unsigned.
REQ-007 rhash  input  256  Scalar h, unsigned; used as a bit string and never reduced.
REQ-008 ready  output  1  Registered; 1 = idle and result valid, 0 = busy.
REQ-009 result  output  1  Registered; 1 = check passed, 0 = check failed.

Function
REQ-010 The block SHALL compute result = ((R + h*A) mod p == S mod p), with R, S and A each first reduced mod p.
REQ-011 FSM states SHALL be IDLE, REDUCE, MUL, ADD and CMP.
REQ-012 IDLE, on edge E0 with valid=1: latch sig, key and rhash; clear ready; enter REDUCE. Inputs may change after E0.
REQ-013 REDUCE SHALL take 2 cycles (E1, E2); each cycle SHALL subtract p from each of A, R and S when that value is >= p. After 2 cycles all three SHALL be < p.
REQ-014 MUL SHALL take 256 cycles (E3..E258) and process rhash MSB-first.
REQ-015 Each MUL cycle SHALL compute acc = 2*acc mod p, then add A mod p when the current bit is 1. acc is cleared at E0.
REQ-016 Each modular step SHALL use a single conditional subtract of p; all operands stay < p, so a 257-bit intermediate suffices.
REQ-017 ADD (E259) SHALL set t = (acc + R) mod p.
REQ-018 CMP (E260) SHALL set result = (t == S), set ready=1 and return to IDLE. Total latency is 260 cycles from acceptance.
REQ-019 result SHALL hold its value until the CMP of the next request. It SHALL not change at acceptance.
REQ-020 valid while ready=0 SHALL be ignored, including in the cycle where CMP completes.
REQ-021 A new request MAY be accepted on the first edge after ready rises (back-to-back).
REQ-022 The computation SHALL be exact for all 256-bit inputs, including key, R or S >= p and h = 0.

Reset
REQ-023 On any edge with resetn=0, the block SHALL set state=IDLE, ready=1 and result=0. This also applies mid-operation, where the request is abandoned.
REQ-024 The first edge with resetn=1 SHALL be able to accept a request.

Verification
REQ-025 Reset: hold resetn=0 for 2 edges -> ready=1, result=0. Assert resetn=0 during MUL -> next edge ready=1, result=0, no later completion.
REQ-026 Pass case: key=1, rhash=1, R=5, S=6 -> ready=0 for 260 cycles, then ready=1, result=1. Repeat with S=7 -> result=0.
REQ-027 Reduction:
- key=2^255-16 (=p+3), rhash=2, R=0, S=6 -> result=1.
- Same with S=p+6 -> result=1.
- key=2^256-1, rhash=1, R=0, S=2^256-1 -> result=1.
REQ-028 Wrap-around: key=p-1, rhash=2, R=2, S=0 -> result=1. rhash=0, R=9, S=9, key=arbitrary -> result=1.
REQ-029 Handshake:
- Pulse valid at cycles 10 and 200 after acceptance -> both ignored; exactly one completion at 260.
- A second request on the first edge after ready rises is accepted; ready stays 1 for exactly one cycle between requests.
REQ-030 Random: 50 random sig/key/rhash requests, half with S forced to (R + h*A) mod p -> result matches a golden model every time.
